// File: rtl/elevador_pequeno.sv
// Five-floor, three-passenger elevator controller with sweep scheduling and an
// emergency descent mode; drives the DE-board seven-segment displays and LEDs.
module elevador_pequeno #(
  parameter int MOVE_CYCLES = 100
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [9:0] LEDR,
  output logic [7:0] LEDG
);

  localparam int TW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MOVE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, EMERG} state_t;

  state_t          state_q, state_d;
  logic [2:0]      floor_q, floor_d;
  logic [1:0]      people_q, people_d;
  logic [4:0]      calls_q, calls_d;
  logic            emerg_q, emerg_d;
  logic            dir_q, dir_d;      // 1 = up
  logic [TW-1:0]   timer_q, timer_d;

  logic [6:0]      sw_p0, sw_p1;      // {SW[9], SW[8], SW[4:0]}
  logic            key0_p0, key0_p1;

  logic            add_rise, rem_rise, emerg_fall, full;
  logic [4:0]      call_rise, call_ok, floor_oh, above, below;

  logic            unused_inputs;
  assign unused_inputs = ^{KEY[3:2], SW[7:5]};

  function automatic logic [1:0] sat_people(input logic [1:0] p, input logic add,
                                            input logic rem);
    if (add && !rem) return (p == 2'd3) ? p : p + 2'd1;
    if (rem && !add) return (p == 2'd0) ? p : p - 2'd1;
    return p;
  endfunction

  function automatic logic [4:0] floor_onehot(input logic [2:0] f);
    logic [4:0] oh;
    for (int i = 0; i < 5; i++) oh[i] = (f == 3'(i + 1));
    return oh;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Stage p0/p1: input capture and previous-sample for edge detection
  always_ff @(posedge CLOCK_50) begin
    sw_p0   <= {SW[9], SW[8], SW[4:0]};
    sw_p1   <= sw_p0;
    key0_p0 <= KEY[0];
    key0_p1 <= key0_p0;
  end

  assign add_rise   = sw_p0[6] & ~sw_p1[6];
  assign rem_rise   = sw_p0[5] & ~sw_p1[5];
  assign call_rise  = sw_p0[4:0] & ~sw_p1[4:0];
  assign emerg_fall = key0_p1 & ~key0_p0;
  assign full       = (people_q == 2'd3);
  assign floor_oh   = floor_onehot(floor_q);

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      above[i] = calls_q[i] & (3'(i + 1) > floor_q);
      below[i] = calls_q[i] & (3'(i + 1) < floor_q);
    end
  end

  // A call for the floor the car is parked at is already served.
  assign call_ok = call_rise & {5{~full & ~emerg_q}} &
                   ~((state_q == IDLE) ? floor_oh : 5'd0);

  // Stage state: next-state logic
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    emerg_d  = emerg_q;
    people_d = sat_people(people_q, add_rise, rem_rise);
    calls_d  = calls_q | call_ok;
    case (state_q)
      IDLE: begin
        if (!full && (above | below) != 5'd0) begin
          dir_d   = dir_q ? (above != 5'd0) : (below == 5'd0);
          state_d = MOVE;
          timer_d = '0;
        end
      end
      MOVE: begin
        if (timer_q == T_LAST) begin
          floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
          calls_d = calls_d & ~floor_onehot(floor_d);
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      EMERG: begin
        if (floor_q == 3'd1) begin
          emerg_d = 1'b0;
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          floor_d = floor_q - 3'd1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (emerg_fall && state_q != EMERG) begin
      emerg_d = 1'b1;
      calls_d = 5'd0;
      dir_d   = 1'b0;
      timer_d = '0;
      state_d = EMERG;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[1]) begin
      state_q  <= IDLE;
      floor_q  <= 3'd1;
      people_q <= 2'd0;
      calls_q  <= 5'd0;
      emerg_q  <= 1'b0;
      dir_q    <= 1'b1;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      people_q <= people_d;
      calls_q  <= calls_d;
      emerg_q  <= emerg_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
    end
  end

  // Stage out: display decode from registered state
  always_comb begin
    if (emerg_q) begin
      HEX0 = seg7(4'd0);
      HEX1 = seg7(4'd9);
      HEX2 = seg7(4'd1);
      HEX3 = seg7(4'hF);
    end else begin
      HEX0 = seg7({1'b0, floor_q});
      HEX1 = seg7(4'hF);
      HEX2 = seg7(4'hF);
      HEX3 = seg7({2'b00, people_q});
    end
    LEDR = {floor_oh, calls_q};
    LEDG = {4'b0000, emerg_q, full,
            (state_q != IDLE) & ~dir_q, (state_q != IDLE) & dir_q};
  end

endmodule

// File: tb/tb_elevador_pequeno.sv
// Scoreboard bench for elevador_pequeno: expected output words are queued as
// stimulus is applied and compared against the displays/LEDs once they settle.
module tb_elevador_pequeno;

  logic       clk;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [9:0] LEDR;
  logic [7:0] LEDG;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam int S_HEX0 = 0, S_HEX1 = 1, S_HEX2 = 2, S_HEX3 = 3, S_LEDR = 4, S_LEDG = 5;
  localparam int BLANK = 10;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];

  elevador_pequeno #(.MOVE_CYCLES(100)) dut (
    .CLOCK_50(clk),
    .KEY     (KEY),
    .SW      (SW),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .LEDR    (LEDR),
    .LEDG    (LEDG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  function automatic int seg(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int ledr(input int f, input int c);
    return ((1 << (f - 1)) << 5) | c;
  endfunction

  function automatic int observe(input int sel);
    case (sel)
      S_HEX0:  return int'(HEX0);
      S_HEX1:  return int'(HEX1);
      S_HEX2:  return int'(HEX2);
      S_HEX3:  return int'(HEX3);
      S_LEDR:  return int'(LEDR);
      default: return int'(LEDG);
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int idx);
    SW[idx] = 1'b1;
    tick(3);
    SW[idx] = 1'b0;
    tick(3);
  endtask

  task automatic wait_floor(input int f, input int budget, output int t);
    int n;
    n = 0;
    while (LEDR[9:5] != 5'(1 << (f - 1)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
  endtask

  initial begin
    int t0, t, tk;
    KEY = 4'b1101;
    SW  = '0;
    tick(5);
    // reset state
    push("rst_hex0", S_HEX0, seg(1));
    push("rst_hex1", S_HEX1, seg(BLANK));
    push("rst_hex2", S_HEX2, seg(BLANK));
    push("rst_hex3", S_HEX3, seg(0));
    push("rst_ledr", S_LEDR, 10'b00001_00000);
    push("rst_ledg", S_LEDG, 0);
    drain();
    KEY = 4'b1111;
    tick(2);

    // passenger counting
    pulse(9);
    pulse(9);
    push("add2_hex3", S_HEX3, seg(2));
    drain();
    pulse(9);
    push("add3_hex3", S_HEX3, seg(3));
    push("add3_full", S_LEDG, 8'h04);
    drain();
    pulse(8);
    push("rem_hex3", S_HEX3, seg(2));
    push("rem_ledg", S_LEDG, 0);
    drain();

    // call floor 3 from floor 1
    t0 = cyc;
    SW[2] = 1'b1;
    tick(3);
    push("c3_ledr", S_LEDR, ledr(1, 5'b00100));
    push("c3_up", S_LEDG, 8'h01);
    drain();
    wait_floor(2, 300, t);
    chk("c3_t_floor2", t - t0, 103);
    push("c3_f2_ledr", S_LEDR, ledr(2, 5'b00100));
    push("c3_f2_hex0", S_HEX0, seg(2));
    drain();
    wait_floor(3, 300, t);
    chk("c3_t_floor3", t - t0, 204);
    push("c3_f3_ledr", S_LEDR, ledr(3, 0));
    push("c3_f3_hex0", S_HEX0, seg(3));
    push("c3_f3_ledg", S_LEDG, 0);
    drain();
    SW[2] = 1'b0;
    tick(2);

    // full car ignores calls and stays put
    pulse(9);
    pulse(9);
    push("sat_hex3", S_HEX3, seg(3));
    push("sat_full", S_LEDG, 8'h04);
    drain();
    SW[0] = 1'b1;
    tick(110);
    push("full_ledr", S_LEDR, ledr(3, 0));
    push("full_hex0", S_HEX0, seg(3));
    drain();
    SW[0] = 1'b0;
    tick(2);
    pulse(8);
    push("unfull_hex3", S_HEX3, seg(2));
    push("unfull_ledg", S_LEDG, 0);
    drain();

    // sweep: calls at 5 and 2 from floor 3 heading up
    t0 = cyc;
    SW[4] = 1'b1;
    SW[1] = 1'b1;
    wait_floor(5, 400, t);
    chk("sw_t_floor5", t - t0, 204);
    push("sw_f5_ledr", S_LEDR, ledr(5, 5'b00010));
    drain();
    wait_floor(2, 500, t);
    chk("sw_t_floor2", t - t0, 507);
    push("sw_f2_ledr", S_LEDR, ledr(2, 0));
    push("sw_f2_hex0", S_HEX0, seg(2));
    drain();
    SW = '0;
    tick(3);

    // emergency during a move
    SW[4:0] = 5'b11111;
    tick(3);
    push("em_pre_ledr", S_LEDR, ledr(2, 5'b11101));
    push("em_pre_down", S_LEDG, 8'h02);
    drain();
    tk = cyc;
    KEY[0] = 1'b0;
    tick(2);
    push("em_ledr", S_LEDR, ledr(2, 0));
    push("em_ledg", S_LEDG, 8'h0A);
    push("em_hex0", S_HEX0, seg(0));
    push("em_hex1", S_HEX1, seg(9));
    push("em_hex2", S_HEX2, seg(1));
    push("em_hex3", S_HEX3, seg(BLANK));
    drain();
    KEY[0] = 1'b1;
    tick(10);
    KEY[0] = 1'b0;
    tick(3);
    KEY[0] = 1'b1;
    wait_floor(1, 660, t);
    chk("em_t_floor1", t - tk, 102);
    tick(2);
    push("em_done_ledg", S_LEDG, 0);
    push("em_done_ledr", S_LEDR, ledr(1, 0));
    push("em_done_hex0", S_HEX0, seg(1));
    push("em_done_hex1", S_HEX1, seg(BLANK));
    push("em_done_hex3", S_HEX3, seg(2));
    drain();
    SW = '0;
    tick(3);

    // reset in the middle of a move
    SW[3] = 1'b1;
    tick(150);
    KEY[1] = 1'b0;
    tick(1);
    push("mr_ledr", S_LEDR, 10'b00001_00000);
    push("mr_ledg", S_LEDG, 0);
    push("mr_hex0", S_HEX0, seg(1));
    push("mr_hex1", S_HEX1, seg(BLANK));
    push("mr_hex2", S_HEX2, seg(BLANK));
    push("mr_hex3", S_HEX3, seg(0));
    drain();
    KEY[1] = 1'b1;
    SW = '0;
    tick(3);
    t0 = cyc;
    SW[1] = 1'b1;
    wait_floor(2, 300, t);
    chk("mr_t_floor2", t - t0, 103);
    push("mr_f2_hex0", S_HEX0, seg(2));
    drain();
    SW = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
